// File: rtl/qbert_pkg.sv
// Shared types and constants for the red-ball spawn scheduler.
package qbert_pkg;

    typedef enum logic [1:0] {
        SC_IDLE   = 2'd0,
        SC_WAIT   = 2'd1,
        SC_LAUNCH = 2'd2,
        SC_ACTIVE = 2'd3
    } brsched_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/br_lfsr.sv
// Free-running 16-bit Galois LFSR (mask LFSR_MASK), one shift per clk cycle.
// Output is the register itself; no enable, no backpressure.
module br_lfsr
    import qbert_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/boule_rouge_sched.sv
// Red-ball spawn scheduler; BR_DIFFICULTY_EN compiles in the shrinking-delay ramp.
// Launch cur_delay*TICK_DIV+1 cycles after SC_WAIT entry; e_enable_br holds until br_end drops.
module boule_rouge_sched
    import qbert_pkg::*;
#(
    parameter int          TICK_DIV    = 50000,
    parameter int          SPAWN_DELAY = 3000,
    parameter int          MIN_DELAY   = 1000,
    parameter int          DELAY_STEP  = 250,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start_qb,
    input  logic        e_pause_qb,
    input  logic        e_resume_qb,
    input  logic        KO_qb,
    input  logic        freeze_power,
    input  logic        br_end,
    input  logic [20:0] spawn_xy_l,
    input  logic [20:0] spawn_xy_r,
    output logic        e_enable_br,
    output logic [5:0]  e_move_br,
    output logic [20:0] e_XY0_br,
    output logic [7:0]  spawn_cnt,
    output logic [1:0]  sched_state
);

    localparam int DLY_W = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY + 1) : 1;
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(SPAWN_DELAY);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);

`ifdef BR_DIFFICULTY_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    brsched_state_t   state_q, state_d;
    logic             paused, halt, tick;
    logic             restart, launch, ack, ball_done;
    logic [PS_W-1:0]  prescaler;
    logic [DLY_W-1:0] delay_cnt, cur_delay, ramp_delay;
    logic [15:0]      lfsr;
    logic             unused_lfsr;

    br_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:7];
    assign halt        = paused | freeze_power;
    assign tick        = !halt && (prescaler == PS_LAST);
    assign sched_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart)        state_d = SC_WAIT;
        else if (launch)    state_d = SC_LAUNCH;
        else if (ack)       state_d = SC_ACTIVE;
        else if (ball_done) state_d = SC_WAIT;
    end

    // Launch ack and end detect ignore halt; only the countdown and launch obey it.
    always_comb begin
        restart   = e_start_qb && (paused || state_q == SC_IDLE);
        launch    = 1'b0;
        ack       = 1'b0;
        ball_done = 1'b0;
        if (!restart) begin
            case (state_q)
                SC_WAIT:   launch    = !halt && !KO_qb && (delay_cnt == '0);
                SC_LAUNCH: ack       = !br_end;
                SC_ACTIVE: ball_done = br_end;
                default:   ;
            endcase
        end
    end

    always_comb begin
        ramp_delay = cur_delay;
        if (RAMP_EN) begin
            if (int'(cur_delay) >= MIN_DELAY + DELAY_STEP) ramp_delay = cur_delay - DLY_W'(DELAY_STEP);
            else                                          ramp_delay = DLY_W'(MIN_DELAY);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused      <= 1'b0;
            prescaler   <= '0;
            delay_cnt   <= '0;
            cur_delay   <= DLY_INIT;
            e_enable_br <= 1'b0;
            e_move_br   <= '0;
            e_XY0_br    <= '0;
            spawn_cnt   <= '0;
        end else begin
            if (restart)          paused <= 1'b0;
            else if (e_pause_qb)  paused <= 1'b1;
            else if (e_resume_qb) paused <= 1'b0;

            if (restart) begin
                e_enable_br <= 1'b0;
                spawn_cnt   <= '0;
                cur_delay   <= DLY_INIT;
                delay_cnt   <= DLY_INIT;
                prescaler   <= '0;
            end else begin
                case (state_q)
                    SC_IDLE: begin
                        delay_cnt <= cur_delay;
                        prescaler <= '0;
                    end
                    SC_WAIT: begin
                        if (KO_qb) begin
                            delay_cnt <= cur_delay;
                            prescaler <= '0;
                        end else if (!halt) begin
                            prescaler <= tick ? '0 : prescaler + PS_W'(1);
                            if (tick && delay_cnt != '0) delay_cnt <= delay_cnt - DLY_W'(1);
                            if (launch) begin
                                e_move_br   <= lfsr[5:0];
                                e_XY0_br    <= lfsr[6] ? spawn_xy_r : spawn_xy_l;
                                e_enable_br <= 1'b1;
                            end
                        end
                    end
                    SC_LAUNCH: begin
                        if (ack) begin
                            e_enable_br <= 1'b0;
                            if (spawn_cnt != 8'hFF) spawn_cnt <= spawn_cnt + 8'd1;
                        end
                    end
                    SC_ACTIVE: begin
                        if (ball_done) begin
                            cur_delay <= ramp_delay;
                            delay_cnt <= ramp_delay;
                            prescaler <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boule_rouge_sched.sv
// Scoreboard bench for boule_rouge_sched: launches are predicted at stimulus time and checked on rise.
module tb_boule_rouge_sched;
    import qbert_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        e_start_qb = 1'b0, e_pause_qb = 1'b0, e_resume_qb = 1'b0;
    logic        KO_qb = 1'b0, freeze_power = 1'b0, br_end = 1'b1;
    logic [20:0] spawn_xy_l = 21'h1A2B3, spawn_xy_r = 21'h0C4D5;
    logic        e_enable_br;
    logic [5:0]  e_move_br;
    logic [20:0] e_XY0_br;
    logic [7:0]  spawn_cnt;
    logic [1:0]  sched_state;

    boule_rouge_sched #(
        .TICK_DIV(4), .SPAWN_DELAY(3), .MIN_DELAY(1), .DELAY_STEP(1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(rst_n),
        .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb), .e_resume_qb(e_resume_qb),
        .KO_qb(KO_qb), .freeze_power(freeze_power), .br_end(br_end),
        .spawn_xy_l(spawn_xy_l), .spawn_xy_r(spawn_xy_r),
        .e_enable_br(e_enable_br), .e_move_br(e_move_br), .e_XY0_br(e_XY0_br),
        .spawn_cnt(spawn_cnt), .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [5:0]  mv;
        logic [20:0] xy;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    logic prev_en = 1'b0;
    int   m_delay = 3;
    int   m_spawn = 0;

    function automatic logic [15:0] lfsr_at(input int c);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < c; i++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
        return v;
    endfunction

    function automatic int gap(input int d);
        return d * 4 + 1;
    endfunction

    // c is the first e_enable_br-high cycle; the path is latched from the cycle before.
    task automatic push_launch(input int c);
        exp_t e;
        logic [15:0] v;
        v    = lfsr_at(c - 1);
        e.cyc = c;
        e.mv  = v[5:0];
        e.xy  = v[6] ? spawn_xy_r : spawn_xy_l;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (e_enable_br && !prev_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_launch", 32'd1, 32'd0);
                end else begin
                    cur_exp = sb.pop_front();
                    chk("launch_cycle", cyc, cur_exp.cyc);
                    chk("launch_move", 32'(e_move_br), 32'(cur_exp.mv));
                    chk("launch_xy", 32'(e_XY0_br), 32'(cur_exp.xy));
                end
            end else if (e_enable_br && prev_en) begin
                chk("move_stable", 32'(e_move_br), 32'(cur_exp.mv));
                chk("xy_stable", 32'(e_XY0_br), 32'(cur_exp.xy));
            end
            prev_en = e_enable_br;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(output int at);
        at = -1;
        for (int i = 0; i < 120; i++) begin
            if (e_enable_br) begin
                at = cyc;
                break;
            end
            step();
        end
        if (at < 0) chk("launch_timeout", 32'd0, 32'd1);
    endtask

    // br_end stays 1 for 'hold' cycles of the launch, then drops; enable must follow one cycle later.
    task automatic ack_ball(input int hold);
        for (int k = 0; k < hold; k++) begin
            chk("en_hold", 32'(e_enable_br), 32'd1);
            step();
        end
        br_end = 1'b0;
        chk("en_ack_cycle", 32'(e_enable_br), 32'd1);
        step();
        m_spawn++;
        chk("en_drop", 32'(e_enable_br), 32'd0);
        chk("spawn_cnt", 32'(spawn_cnt), m_spawn);
        chk("state_active", 32'(sched_state), 32'(SC_ACTIVE));
    endtask

    task automatic end_ball(input int flight, output int f);
        for (int k = 0; k < flight; k++) step();
        br_end = 1'b1;
        f = cyc;
`ifdef BR_DIFFICULTY_EN
        if (m_delay > 1) m_delay--;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, f, l;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_enable", 32'(e_enable_br), 32'd0);
        chk("rst_move", 32'(e_move_br), 32'd0);
        chk("rst_xy", 32'(e_XY0_br), 32'd0);
        chk("rst_spawn_cnt", 32'(spawn_cnt), 32'd0);
        chk("rst_state", 32'(sched_state), 32'(SC_IDLE));
        rst_n = 1'b1;
        step();
        step();
        chk("idle_hold", 32'(sched_state), 32'(SC_IDLE));

        // First launch from start, with a 5-cycle acceptance hold.
        e_start_qb = 1'b1;
        s = cyc;
        push_launch(s + 1 + gap(m_delay));
        step();
        e_start_qb = 1'b0;
        chk("start_to_wait", 32'(sched_state), 32'(SC_WAIT));
        wait_launch(l);
        chk("state_launch", 32'(sched_state), 32'(SC_LAUNCH));
        ack_ball(5);

        // Pause+resume in one cycle leaves paused set; 20 paused cycles push the launch by 20.
        end_ball(7, f);
        push_launch(f + 1 + gap(m_delay) + 20);
        while (cyc < f + 5) step();
        e_pause_qb = 1'b1;
        e_resume_qb = 1'b1;
        step();
        e_pause_qb = 1'b0;
        e_resume_qb = 1'b0;
        while (cyc < f + 25) step();
        chk("paused_state", 32'(sched_state), 32'(SC_WAIT));
        chk("paused_no_enable", 32'(e_enable_br), 32'd0);
        e_resume_qb = 1'b1;
        step();
        e_resume_qb = 1'b0;
        wait_launch(l);
        ack_ball(0);

        // KO for 6 cycles: the full delay restarts once KO falls.
        end_ball(5, f);
        push_launch(f + 9 + gap(m_delay));
        while (cyc < f + 3) step();
        KO_qb = 1'b1;
        repeat (6) step();
        KO_qb = 1'b0;
        wait_launch(l);
        ack_ball(2);

        // Freeze for 7 cycles holds the count.
        end_ball(4, f);
        push_launch(f + 1 + gap(m_delay) + 7);
        while (cyc < f + 2) step();
        freeze_power = 1'b1;
        repeat (7) step();
        freeze_power = 1'b0;
        wait_launch(l);
        ack_ball(1);

        // Start while running is ignored; start+pause while paused restarts with paused cleared.
        repeat (2) step();
        e_start_qb = 1'b1;
        step();
        e_start_qb = 1'b0;
        step();
        chk("start_ignored_state", 32'(sched_state), 32'(SC_ACTIVE));
        chk("start_ignored_cnt", 32'(spawn_cnt), m_spawn);
        e_pause_qb = 1'b1;
        step();
        e_pause_qb = 1'b0;
        repeat (2) step();
        e_start_qb = 1'b1;
        e_pause_qb = 1'b1;
        s = cyc;
        m_delay = 3;
        m_spawn = 0;
        push_launch(s + 1 + gap(m_delay));
        step();
        e_start_qb = 1'b0;
        e_pause_qb = 1'b0;
        chk("restart_state", 32'(sched_state), 32'(SC_WAIT));
        chk("restart_cnt", 32'(spawn_cnt), 32'd0);
        chk("restart_enable", 32'(e_enable_br), 32'd0);
        br_end = 1'b1;
        wait_launch(l);
        ack_ball(0);

        repeat (10) step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/boule_rouge_sched.md
Name: boule_rouge_sched

Overview:
- Spawn scheduler for the red-ball enemy layer; sits between the game-state logic and the red-ball layer.
- Drives that layer's enable, 6-bit path and spawn-position inputs, and waits for the ball to finish before scheduling the next one.
- Handles pause/resume/restart, Q*bert KO and the freeze power-up.
- Replaces the fixed enable/path currently wired from the top level.

Parameters:
- TICK_DIV, 50000, clk cycles per scheduler tick (1 ms at 50 MHz).
- SPAWN_DELAY, 3000, ticks between ball end (or game start) and next launch.
- MIN_DELAY, 1000, floor for the delay when difficulty ramp is compiled in.
- DELAY_STEP, 250, delay decrement per completed ball (ramp only).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- e_start_qb  in  1  start/restart pulse
- e_pause_qb  in  1  pause pulse
- e_resume_qb  in  1  resume pulse
- KO_qb  in  1  Q*bert knocked out (level)
- freeze_power  in  1  freeze power-up active (level)
- br_end  in  1  from ball layer: 1 = ball idle/finished, 0 = ball in flight
- spawn_xy_l  in  21  {x[10:0],y[9:0]} of left top-row cube
- spawn_xy_r  in  21  {x,y} of right top-row cube
- e_enable_br  out  1  launch request to ball layer
- e_move_br  out  6  path bits, bit i = direction of move i (0 up-right, 1 down-right)
- e_XY0_br  out  21  spawn cube position
- spawn_cnt  out  8  balls launched since start, saturating at 255
- sched_state  out  2  current FSM state, for debug/score logic

Behaviour:
- Reset (async, reset=0):
  - Outputs: e_enable_br=0, e_move_br=0, e_XY0_br=0, spawn_cnt=0.
  - Internal: state=SC_IDLE, lfsr=LFSR_SEED, cur_delay=SPAWN_DELAY, prescaler=0, delay_cnt=0, paused=0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clk cycle unconditionally, including while paused.
- Pause flag:
  - e_pause_qb sets the flag; e_resume_qb clears it.
  - If both arrive in the same cycle, pause wins.
- halt = paused | freeze_power.
  - While halt, the prescaler and delay_cnt hold.
  - FSM transitions are blocked, except the SC_LAUNCH ack and the SC_ACTIVE end detect.
- Tick: prescaler counts 0..TICK_DIV-1 while not halt; tick=1 in the cycle it wraps to 0.
- FSM (sched_state encoding 0..3):
  - SC_IDLE:
    - e_start_qb goes to SC_WAIT.
    - delay_cnt<=cur_delay, prescaler<=0.
  - SC_WAIT:
    - On tick, delay_cnt decrements.
    - While KO_qb=1, delay_cnt reloads to cur_delay and prescaler clears.
    - When delay_cnt==0 and !halt:
      - latch e_move_br<=lfsr[5:0] and e_XY0_br<= lfsr[6] ? spawn_xy_r : spawn_xy_l;
      - e_enable_br<=1;
      - go to SC_LAUNCH.
    - First e_enable_br high cycle = entry + cur_delay*TICK_DIV + 1 when not halted.
  - SC_LAUNCH:
    - e_enable_br held 1 until br_end==0 (ball accepted).
    - Then e_enable_br<=0, spawn_cnt++ (saturating), go to SC_ACTIVE.
  - SC_ACTIVE:
    - On br_end==1: delay_cnt<=cur_delay (after ramp update), go to SC_WAIT.
    - KO, freeze and scene change are handled by the ball layer; the scheduler only waits for br_end.
- e_move_br and e_XY0_br are stable from launch until the next launch; they never change while e_enable_br=1.
- Restart (e_start_qb while paused, or in SC_IDLE):
  - paused<=0, e_enable_br<=0, spawn_cnt<=0, cur_delay<=SPAWN_DELAY, go to SC_WAIT with reload.
  - Applies even mid-SC_LAUNCH or mid-SC_ACTIVE.
  - e_start_qb while not paused and not in SC_IDLE is ignored.
- Simultaneous restart and pause: restart wins, paused ends 0.

Optional Feature:
- Macro: BR_DIFFICULTY_EN.
- Defined: on each SC_ACTIVE to SC_WAIT transition, cur_delay <= max(cur_delay-DELAY_STEP, MIN_DELAY), with no underflow. Restart restores SPAWN_DELAY.
- Undefined: cur_delay is constant SPAWN_DELAY; MIN_DELAY and DELAY_STEP are unused.

Decomposition:
- qbert_pkg holds:
  - typedef enum logic [1:0] brsched_state_t {SC_IDLE, SC_WAIT, SC_LAUNCH, SC_ACTIVE};
  - localparam LFSR_MASK = 16'hB400.
- Sub-module br_lfsr: ports clk, reset, q[15:0]; parameter SEED.

Test Plan (TICK_DIV=4, SPAWN_DELAY=3, MIN_DELAY=1, DELAY_STEP=1):
- Reset, then e_start_qb pulse -> e_enable_br rises 13 cycles after SC_WAIT entry; e_move_br==lfsr[5:0] at the launch cycle; e_XY0_br selects spawn_xy_l or spawn_xy_r per lfsr[6].
- Hold br_end=1 for 5 cycles after launch, then drop to 0 -> e_enable_br stays 1 for exactly those cycles, then 0; spawn_cnt=1; sched_state=SC_ACTIVE.
- Pause for 20 cycles mid-SC_WAIT, then resume -> launch delayed by exactly 20 cycles; e_pause_qb+e_resume_qb in same cycle -> paused.
- KO_qb high for 6 cycles in SC_WAIT -> delay restarts from 3 ticks after KO falls; freeze_power likewise holds the count.
- Mid-SC_ACTIVE: pause, then e_start_qb -> e_enable_br=0, spawn_cnt=0, SC_WAIT, next launch after 13 cycles.
- BR_DIFFICULTY_EN: three complete balls -> gaps of 3, 2, 1, 1 ticks; without the macro, gaps stay 3 ticks.
